// File: rtl/vi_sel_pkg.sv
// Shared types and constants for the video input source selector.
// State encoding, select-width helper and default I2C mux codes.
package vi_sel_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        BLANK = 1'b1
    } state_t;

    localparam logic [2:0] HDMI_SEL = 3'b100;
    localparam logic [2:0] CMOS_SEL = 3'b101;

    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vi_sel_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, press pulse.
// o_press is a 1-cycle pulse on each debounced high-to-low transition.
module vi_sel_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]    r_sync;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    // Idle level of the active-low button is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= 2'b11;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_press <= 1'b0;
            if (r_sync[1] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
                r_cnt    <= '0;
                r_stable <= r_sync[1];
                r_press  <= ~r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/vi_source_sel.sv
// N-way video source selector with frame-aligned switching and no-signal detect.
// Define VI_SEL_AUTO_SCAN_EN to auto-advance the source on each timeout.
module vi_source_sel
    import vi_sel_pkg::*;
#(
    parameter int NUM_SRC      = 2,
    parameter int DATA_W       = 16,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int TIMEOUT_CYC  = 50000000,
    parameter logic [3*NUM_SRC-1:0] I2C_CODES = {CMOS_SEL, HDMI_SEL},
    localparam int SEL_W       = sel_w(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      btn,
    input  logic                      sw_req,
    input  logic [SEL_W-1:0]          sw_idx,
    input  logic [NUM_SRC-1:0]        src_vs,
    input  logic [NUM_SRC-1:0]        src_de,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic                      vo_vs,
    output logic                      vo_de,
    output logic [DATA_W-1:0]         vo_data,
    output logic [SEL_W-1:0]          cur_src,
    output logic [2:0]                i2c_sel,
    output logic                      switching,
    output logic                      no_signal
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t             r_state;
    logic [SEL_W-1:0]   r_cur;
    logic [2:0]         r_i2c;
    logic [TW-1:0]      r_tmo;
    logic               r_nosig;
    logic [NUM_SRC-1:0] r_vs_d;
    logic               r_vo_vs;
    logic               r_vo_de;
    logic [DATA_W-1:0]  r_vo_data;

    state_t             w_state_nx;
    logic               w_press;
    logic               w_sw_ok;
    logic               w_press_ok;
    logic               w_load;
    logic               w_tmo_hit;
    logic               w_tmo_end;
    logic               w_edge;
    logic [SEL_W-1:0]   w_nxt;
    logic [SEL_W-1:0]   w_tgt;
    logic [2:0]         w_code;
    logic               w_vs;
    logic               w_vs_d;
    logic               w_de;
    logic [DATA_W-1:0]  w_data;

    vi_sel_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (btn),
        .o_press(w_press)
    );

    always_comb begin
        w_vs   = 1'b0;
        w_vs_d = 1'b0;
        w_de   = 1'b0;
        w_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (r_cur == SEL_W'(k)) begin
                w_vs   = src_vs[k];
                w_vs_d = r_vs_d[k];
                w_de   = src_de[k];
                w_data = src_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_nxt = (r_cur == SEL_W'(NUM_SRC - 1)) ? '0 : r_cur + 1'b1;
    assign w_sw_ok = sw_req && (int'(sw_idx) < NUM_SRC) &&
                     !(r_state == RUN && sw_idx == r_cur);
    // Software select has priority; a coincident press is discarded
    assign w_press_ok = w_press && !sw_req;
    assign w_edge = w_vs && !w_vs_d;
    assign w_tmo_end = (r_tmo == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_tgt      = w_nxt;
        w_tmo_hit  = 1'b0;
        if (w_sw_ok) begin
            w_load = 1'b1;
            w_tgt  = sw_idx;
        end else if (w_press_ok) begin
            w_load = 1'b1;
        end
        unique case (r_state)
            RUN: begin
                if (w_load) w_state_nx = BLANK;
            end
            BLANK: begin
                if (!w_load) begin
                    if (w_edge) begin
                        w_state_nx = RUN;
                    end else if (w_tmo_end) begin
                        w_tmo_hit = 1'b1;
`ifdef VI_SEL_AUTO_SCAN_EN
                        w_load = 1'b1;
`endif
                    end
                end
            end
        endcase
    end

    always_comb begin
        w_code = I2C_CODES[2:0];
        for (int k = 0; k < NUM_SRC; k++) begin
            if (w_tgt == SEL_W'(k)) w_code = I2C_CODES[3*k +: 3];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cur   <= '0;
            r_i2c   <= I2C_CODES[2:0];
            r_tmo   <= '0;
            r_nosig <= 1'b0;
            r_vs_d  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_vs_d  <= src_vs;
            if (w_load) begin
                r_cur <= w_tgt;
                r_i2c <= w_code;
                r_tmo <= '0;
            end else if (r_state == RUN) begin
                r_tmo <= '0;
            end else if (r_tmo != TW'(TIMEOUT_CYC)) begin
                r_tmo <= r_tmo + 1'b1;
            end
`ifdef VI_SEL_AUTO_SCAN_EN
            r_nosig <= w_tmo_hit;
`else
            if (w_state_nx == RUN) r_nosig <= 1'b0;
            else if (w_tmo_hit) r_nosig <= 1'b1;
`endif
        end
    end

    // Output stage blanks whenever the next cycle is not a RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vo_vs   <= 1'b0;
            r_vo_de   <= 1'b0;
            r_vo_data <= '0;
        end else if (w_state_nx == RUN) begin
            r_vo_vs   <= w_vs;
            r_vo_de   <= w_de;
            r_vo_data <= w_data;
        end else begin
            r_vo_vs   <= 1'b0;
            r_vo_de   <= 1'b0;
            r_vo_data <= '0;
        end
    end

    assign vo_vs     = r_vo_vs;
    assign vo_de     = r_vo_de;
    assign vo_data   = r_vo_data;
    assign cur_src   = r_cur;
    assign i2c_sel   = r_i2c;
    assign switching = (r_state == BLANK);
    assign no_signal = r_nosig;

endmodule
